// File: rtl/ctrl_relogio.sv
// Central sequencer for the HH:MM:SS clock: advance-tick prescaler, button edge
// detection, RUN / SET_HOUR / SET_MIN mode FSM and display blink phase.
module ctrl_relogio #(
    parameter int DIV       = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       ctrl_clock,
    input  logic       ctrl_reset,
    input  logic       ctrl_btn_modo,
    input  logic       ctrl_btn_inc,
    input  logic       ctrl_fim_seg,
    input  logic       ctrl_fim_min,
    output logic       ctrl_en_seg,
    output logic       ctrl_zera_seg,
    output logic       ctrl_inc_min,
    output logic       ctrl_inc_hora,
    output logic       ctrl_pisca_hora,
    output logic       ctrl_pisca_min,
    output logic [1:0] ctrl_estado
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        INVALID  = 2'b11
    } estado_t;

    estado_t       estado, estado_nxt;
    logic [1:0]    modo_sync, inc_sync;
    logic          modo_hist, inc_hist;
    logic          modo_edge, inc_edge;
    logic [PW-1:0] presc;
    logic          tick, clr_presc;
    logic [BW-1:0] blink_cnt;
    logic          blink_fase;
    logic          en_seg_d, zera_seg_d, inc_min_d, inc_hora_d;

    // Synchronizer and history reset high, so a button held through reset
    // looks already pressed and must be released before it counts again.
    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset) begin
            modo_sync <= 2'b11;
            inc_sync  <= 2'b11;
            modo_hist <= 1'b1;
            inc_hist  <= 1'b1;
            modo_edge <= 1'b0;
            inc_edge  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each flop samples pre-edge values.
            modo_sync <= {modo_sync[0], ctrl_btn_modo};
            inc_sync  <= {inc_sync[0], ctrl_btn_inc};
            modo_hist <= modo_sync[1];
            inc_hist  <= inc_sync[1];
            modo_edge <= modo_sync[1] & ~modo_hist;
            inc_edge  <= inc_sync[1] & ~inc_hist;
        end
    end

    assign tick = (presc == DIV_LAST);

    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset || clr_presc || tick) presc <= '0;
        else                                 presc <= presc + PW'(1);
    end

    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset) estado <= RUN;
        else            estado <= estado_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        estado_nxt = estado;
        en_seg_d   = 1'b0;
        zera_seg_d = 1'b0;
        inc_min_d  = 1'b0;
        inc_hora_d = 1'b0;
        clr_presc  = 1'b0;
        case (estado)
            RUN: begin
                en_seg_d   = tick;
                inc_min_d  = tick & ctrl_fim_seg;
                inc_hora_d = tick & ctrl_fim_seg & ctrl_fim_min;
                if (modo_edge) estado_nxt = SET_HOUR;
            end
            SET_HOUR: begin
                if (modo_edge) estado_nxt = SET_MIN;
                else           inc_hora_d = inc_edge;
            end
            SET_MIN: begin
                // Leaving setup restarts the second from zero.
                if (modo_edge) begin
                    estado_nxt = RUN;
                    zera_seg_d = 1'b1;
                    clr_presc  = 1'b1;
                end else begin
                    inc_min_d = inc_edge;
                end
            end
            default: estado_nxt = RUN;
        endcase
    end

    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset) begin
            ctrl_en_seg   <= 1'b0;
            ctrl_zera_seg <= 1'b0;
            ctrl_inc_min  <= 1'b0;
            ctrl_inc_hora <= 1'b0;
        end else begin
            ctrl_en_seg   <= en_seg_d;
            ctrl_zera_seg <= zera_seg_d;
            ctrl_inc_min  <= inc_min_d;
            ctrl_inc_hora <= inc_hora_d;
        end
    end

    // Blink restarts from phase 0 whenever the mode changes.
    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset || (estado_nxt != estado)) begin
            blink_cnt  <= '0;
            blink_fase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt  <= '0;
            blink_fase <= ~blink_fase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign ctrl_pisca_hora = (estado == SET_HOUR) & blink_fase;
    assign ctrl_pisca_min  = (estado == SET_MIN) & blink_fase;
    assign ctrl_estado     = estado;

endmodule

// File: tb/tb_ctrl_relogio.sv
// Self-checking bench for ctrl_relogio: fixed vector table, directed mode/button
// sequences, and a random run compared against a cycle-level behavioural model.
module tb_ctrl_relogio;

    localparam int DIV   = 4;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       rst, btn_modo, btn_inc, fim_seg, fim_min;
    logic       en_seg, zera_seg, inc_min, inc_hora, pisca_hora, pisca_min;
    logic [1:0] estado;

    always #5 clk = ~clk;

    ctrl_relogio #(.DIV(DIV), .BLINK_DIV(BLINK)) dut (
        .ctrl_clock     (clk),
        .ctrl_reset     (rst),
        .ctrl_btn_modo  (btn_modo),
        .ctrl_btn_inc   (btn_inc),
        .ctrl_fim_seg   (fim_seg),
        .ctrl_fim_min   (fim_min),
        .ctrl_en_seg    (en_seg),
        .ctrl_zera_seg  (zera_seg),
        .ctrl_inc_min   (inc_min),
        .ctrl_inc_hora  (inc_hora),
        .ctrl_pisca_hora(pisca_hora),
        .ctrl_pisca_min (pisca_min),
        .ctrl_estado    (estado)
    );

    typedef struct {
        logic       r;
        logic       fs;
        logic       fm;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[18];

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_en, cnt_zera, cnt_imin, cnt_ihora, cnt_chg;
    logic [1:0] prev_estado = 2'b00;

    // Reference model: mode number, edge counter, anchors for the tick and
    // blink periods, and the recent sampled button levels (newest first).
    int         m_mode = 0;
    longint     m_cyc = 0, m_anchor_p = 0, m_anchor_b = 0;
    logic       qm[$];
    logic       qi[$];
    logic [7:0] exp_vec;

    function automatic logic [7:0] dut_vec();
        return {en_seg, zera_seg, inc_min, inc_hora, pisca_hora, pisca_min, estado};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, m_cyc, got, want);
    endtask

    // A press acts on the edge whose 3rd-previous sample is high and 4th-previous is low.
    task automatic model_edge(input logic r, input logic m, input logic i,
                              input logic fs, input logic fm);
        logic mp, ip, tick, phase, en_e, zr_e, im_e, ih_e;
        int   nxt;
        m_cyc++;
        en_e = 1'b0; zr_e = 1'b0; im_e = 1'b0; ih_e = 1'b0;
        if (r) begin
            m_mode     = 0;
            m_anchor_p = m_cyc;
            m_anchor_b = m_cyc;
            qm = '{1'b1, 1'b1, 1'b1, 1'b1};
            qi = '{1'b1, 1'b1, 1'b1, 1'b1};
        end else begin
            mp   = qm[2] && !qm[3];
            ip   = qi[2] && !qi[3];
            tick = ((m_cyc - m_anchor_p) % DIV) == 0;
            nxt  = m_mode;
            case (m_mode)
                0: begin
                    en_e = tick;
                    im_e = tick && fs;
                    ih_e = tick && fs && fm;
                    if (mp) nxt = 1;
                end
                1: if (mp) nxt = 2; else ih_e = ip;
                default: begin
                    if (mp) begin
                        nxt        = 0;
                        zr_e       = 1'b1;
                        m_anchor_p = m_cyc;
                    end else begin
                        im_e = ip;
                    end
                end
            endcase
            if (nxt != m_mode) m_anchor_b = m_cyc;
            m_mode = nxt;
            qm.push_front(m); void'(qm.pop_back());
            qi.push_front(i); void'(qi.pop_back());
        end
        phase   = (((m_cyc - m_anchor_b) / BLINK) % 2) == 1;
        exp_vec = {en_e, zr_e, im_e, ih_e, (m_mode == 1) && phase, (m_mode == 2) && phase,
                   2'(m_mode)};
    endtask

    task automatic step(input logic r, input logic m, input logic i,
                        input logic fs, input logic fm);
        @(negedge clk);
        rst = r; btn_modo = m; btn_inc = i; fim_seg = fs; fim_min = fm;
        @(posedge clk);
        model_edge(r, m, i, fs, fm);
        #1;
        check("model", 32'(dut_vec()), 32'(exp_vec));
        cnt_en    += int'(en_seg);
        cnt_zera  += int'(zera_seg);
        cnt_imin  += int'(inc_min);
        cnt_ihora += int'(inc_hora);
        if (estado != prev_estado) cnt_chg++;
        prev_estado = estado;
    endtask

    task automatic clear_counts();
        cnt_en = 0; cnt_zera = 0; cnt_imin = 0; cnt_ihora = 0; cnt_chg = 0;
    endtask

    task automatic press(input logic is_mode, input int hi, input int lo);
        for (int k = 0; k < hi; k++) step(1'b0, is_mode, !is_mode, 1'b0, 1'b0);
        for (int k = 0; k < lo; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic m_lvl, i_lvl, r_rnd, fs_rnd, fm_rnd;
        rst = 1'b1; btn_modo = 1'b0; btn_inc = 1'b0; fim_seg = 1'b0; fim_min = 1'b0;
        clear_counts();

        // {reset, fim_seg, fim_min, expected {en,zera,imin,ihora,ph,pm,estado}}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h80};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h80};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h00};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h00};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 8'hB0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'hA0};

        for (int k = 0; k < 18; k++) begin
            step(tbl[k].r, 1'b0, 1'b0, tbl[k].fs, tbl[k].fm);
            check($sformatf("table[%0d]", k), 32'(dut_vec()), 32'(tbl[k].exp));
        end

        // Mode press held 20 cycles: one transition after 4 edges, seconds frozen.
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 3) check("mode_not_yet", 32'(estado), 32'd0);
        end
        check("mode_to_set_hour", 32'(estado), 32'd1);
        clear_counts();
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("en_frozen_set_hour", 32'(cnt_en), 32'd0);
        check("single_mode_edge", 32'(cnt_chg), 32'd0);
        press(1'b0, 0, 4);
        press(1'b1, 4, 4);
        check("mode_to_set_min", 32'(estado), 32'd2);
        clear_counts();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mode_to_run", 32'(estado), 32'd0);
        check("zera_on_exit", 32'(zera_seg), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("en_after_exit+%0d", k), 32'(en_seg), 32'(k == 4));
        end
        check("zera_once", 32'(cnt_zera), 32'd1);

        // Increment presses in each setting mode and in RUN.
        press(1'b1, 4, 4);
        check("enter_set_hour", 32'(estado), 32'd1);
        clear_counts();
        for (int k = 0; k < 3; k++) press(1'b0, 5, 4);
        check("set_hour_inc_hora", 32'(cnt_ihora), 32'd3);
        check("set_hour_inc_min", 32'(cnt_imin), 32'd0);
        press(1'b1, 4, 4);
        clear_counts();
        for (int k = 0; k < 2; k++) press(1'b0, 5, 4);
        check("set_min_inc_min", 32'(cnt_imin), 32'd2);
        check("set_min_inc_hora", 32'(cnt_ihora), 32'd0);
        press(1'b1, 4, 4);
        check("back_in_run", 32'(estado), 32'd0);
        clear_counts();
        press(1'b0, 5, 4);
        check("run_ignores_inc", 32'(cnt_imin + cnt_ihora), 32'd0);

        // Blink phase in SET_HOUR starts at 0 and toggles every BLINK cycles.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("blink_entry", 32'({estado, pisca_hora, pisca_min}), 32'b0100);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("blink+%0d", k), 32'({pisca_hora, pisca_min}),
                  32'(((k / 2) % 2) * 2));
        end

        // Mode and inc rising together in SET_HOUR: mode wins, no increment.
        clear_counts();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("simul_mode_wins", 32'(estado), 32'd2);
        press(1'b0, 0, 4);
        check("simul_inc_dropped", 32'(cnt_imin + cnt_ihora), 32'd0);

        // Buttons held through reset are ignored until pressed again.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        clear_counts();
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("held_reset_no_state", 32'(cnt_chg), 32'd0);
        check("held_reset_no_inc", 32'(cnt_imin + cnt_ihora), 32'd0);
        press(1'b0, 0, 4);
        press(1'b1, 4, 4);
        check("press_after_reset", 32'(estado), 32'd1);

        // Reset while in SET_MIN.
        press(1'b1, 4, 4);
        check("pre_reset_set_min", 32'(estado), 32'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_in_set_min", 32'(dut_vec()), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_reset_idle", 32'(dut_vec()), 32'd0);

        // Random run against the model.
        m_lvl = 1'b0;
        i_lvl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) m_lvl = ~m_lvl;
            if ($urandom_range(0, 5) == 0) i_lvl = ~i_lvl;
            r_rnd  = ($urandom_range(0, 499) == 0);
            fs_rnd = 1'($urandom_range(0, 1));
            fm_rnd = ($urandom_range(0, 2) != 0);
            step(r_rnd, m_lvl, i_lvl, fs_rnd, fm_rnd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_relogio.md
Name: ctrl_relogio

Overview:
Central sequencer for the HH:MM:SS clock datapath. It divides the system clock into a 1 Hz advance tick and gates that tick to the seconds machine. It chains the seconds→minutes→hours carries, and runs a mode FSM (RUN / SET_HOUR / SET_MIN) driven by two pushbuttons, so the user can set the time while the displays blink. It sits between the board buttons and the counting machines (seconds, minutes, hours), and drives their enable/clear inputs.

Parameters:
DIV, 50000000, system-clock cycles per advance tick (≥2)
BLINK_DIV, 12500000, system-clock cycles per blink-phase toggle (≥1)

Ports:
ctrl_clock  in  1  system clock; all logic on rising edge
ctrl_reset  in  1  synchronous reset, active-high
ctrl_btn_modo  in  1  mode button level, asynchronous to clock, already debounced
ctrl_btn_inc  in  1  increment button level, asynchronous, already debounced
ctrl_fim_seg  in  1  seconds machine at 59 (its inc_minuto carry)
ctrl_fim_min  in  1  minutes machine at 59
ctrl_en_seg  out  1  1-cycle enable: seconds machine advances
ctrl_zera_seg  out  1  1-cycle clear of seconds machine
ctrl_inc_min  out  1  1-cycle increment of minutes machine
ctrl_inc_hora  out  1  1-cycle increment of hours machine
ctrl_pisca_hora  out  1  1 = blank hour digits this cycle
ctrl_pisca_min  out  1  1 = blank minute digits this cycle
ctrl_estado  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 never driven)

Behaviour:
- Reset (ctrl_reset=1 at a rising edge): state RUN; prescaler 0; blink counter 0; blink phase 0; all pulse outputs 0; pisca outputs 0.
- Reset values: button synchronizer flops and edge-history flops reset to 1. A button held through reset is not counted; it must be released and pressed again. Reset mid-operation aborts any state immediately.
- Prescaler: counts 0..DIV-1 and wraps. tick = (count==DIV-1). It runs in all states.
- Blink counter: counts 0..BLINK_DIV-1 and wraps. Blink phase toggles on wrap. Counter and phase are cleared to 0 on every state change.
- Buttons: 2-flop synchronizer, then rising-edge detect against a history flop. Edge fires on the 3rd rising clock edge that samples the input high. The resulting action is registered and visible on outputs one cycle later. Exactly one edge per press, regardless of hold time.
- FSM on mode edge: RUN→SET_HOUR→SET_MIN→RUN.
- On SET_MIN→RUN, in the same cycle:
  - ctrl_zera_seg pulses for 1 cycle.
  - Prescaler is cleared to 0, so the first en_seg occurs exactly DIV cycles after the transition.
- RUN outputs (all registered, asserted the cycle after the tick cycle):
  - ctrl_en_seg = tick.
  - ctrl_inc_min = tick & ctrl_fim_seg.
  - ctrl_inc_hora = tick & ctrl_fim_seg & ctrl_fim_min.
  - Inc button edges are ignored.
- SET_HOUR: ctrl_en_seg forced 0 (seconds frozen). ctrl_inc_hora = inc edge. ctrl_inc_min = 0. ctrl_pisca_hora = blink phase. ctrl_pisca_min = 0.
- SET_MIN: ctrl_en_seg forced 0. ctrl_inc_min = inc edge. ctrl_inc_hora = 0 (no carry into hours while setting). ctrl_pisca_min = blink phase. ctrl_pisca_hora = 0.
- Simultaneous mode and inc edges in the same cycle: mode wins and the inc edge is discarded.
- Tick in the same cycle as a mode edge leaving RUN: the tick is still honoured (decision uses the pre-transition state).
- Pulse outputs are never high for 2 consecutive cycles, except under DIV=1, which is illegal.
- Hour/minute wrap-around (23→00, 59→00) belongs to the counting machines. This block only issues increments.
- ctrl_estado mirrors the state register. Value 11 is unreachable; if entered, the next cycle goes to RUN.

Test Plan:
- Reset, DIV=4, no buttons: after reset release, ctrl_en_seg pulses at cycles 4, 8, 12, … (1-cycle each). ctrl_inc_min and ctrl_inc_hora stay 0 with fim_seg=0.
- RUN, DIV=4, fim_seg=1, fim_min=1: ctrl_en_seg, ctrl_inc_min and ctrl_inc_hora all pulse on the same cycle. With fim_min=0, only en_seg and inc_min pulse.
- Mode press held 20 cycles, from RUN: ctrl_estado goes 00→01 exactly once, 4 cycles after the press, and en_seg stops. Second press → 10. Third press → 00, with ctrl_zera_seg pulsing once and the next en_seg exactly DIV cycles later.
- SET_HOUR with 3 inc presses: exactly 3 ctrl_inc_hora pulses and 0 ctrl_inc_min pulses. Then SET_MIN with 2 presses: exactly 2 ctrl_inc_min pulses and 0 ctrl_inc_hora pulses. In RUN, an inc press produces no pulse.
- BLINK_DIV=2, in SET_HOUR: ctrl_pisca_hora toggles every 2 cycles starting at 0 after entry, and ctrl_pisca_min stays 0. In RUN, both pisca outputs stay 0.
- Mode and inc rising in the same cycle while in SET_HOUR: state becomes SET_MIN and no increment is issued. Buttons held high through reset: no state change until released and pressed again. Reset asserted while in SET_MIN: returns to 00, with all outputs 0 on the next cycle.
